imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RISC-V core. It extracts and sign- or zero-extends immediates for all RV32/RV64 base formats to XLEN bits, and optionally for a subset of compressed formats. It replaces the combinational extender between decode and execute with a registered, valid/ready-handshaked stage. A built-in skid buffer sustains one result per cycle under back-pressure.

---
 rtl/imm_gen_pipe_if.sv | 25 ++
 rtl/imm_gen_pipe.sv | 129 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Purpose: bundles the decode-side and execute-side handshake of imm_gen_pipe.
// Latency: none, this is wiring only.
// Backpressure: carries in_ready and out_ready. The slave modport is the stage side and the master modport is the driver/consumer side.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;   // instruction/format pair offered
    logic            in_ready;   // stage can accept
    logic [31:0]     In;         // instruction word (RVC in In[15:0])
    logic [3:0]      ImmSrc;     // format select
    logic            out_valid;  // Imm_Ext/err hold a result
    logic            out_ready;  // consumer accepts
    logic [XLEN-1:0] Imm_Ext;    // extended immediate
    logic            err;        // result came from an illegal ImmSrc

    modport slave (
        input  in_valid, In, ImmSrc, out_ready,
        output in_ready, out_valid, Imm_Ext, err
    );

    modport master (
        output in_valid, In, ImmSrc, out_ready,
        input  in_ready, out_valid, Imm_Ext, err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Purpose: registered RISC-V immediate extractor/extender (I/S/B/J/U/SHAMT, optional RVC) to XLEN bits.
// Latency: 1 cycle, from acceptance edge to out_valid.
// Backpressure: a one-entry skid register absorbs one beat. in_ready is the registered "skid empty" flag.
// Ports: clk; rst (async, active-low); bus (imm_gen_pipe_if.slave) = in_valid/in_ready/In/ImmSrc, out_valid/out_ready/Imm_Ext/err.
// Config: define IMMGEN_RVC_EN to decode compressed formats on ImmSrc 1000-1011. Otherwise all 1xxx codes are illegal.
module imm_gen_pipe #(
    parameter int XLEN = 32   // 32 or 64
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    // ---------------- decode ----------------
    // Every format is built 64 bits wide and then truncated to XLEN.
    // This keeps the sign fill identical for both widths.
    logic [63:0]     imm_full;
    logic            dec_err;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        imm_full = '0;
        dec_err  = 1'b0;
        case (bus.ImmSrc)
            4'b0000: imm_full = {{52{bus.In[31]}}, bus.In[31:20]};
            4'b0001: imm_full = {{52{bus.In[31]}}, bus.In[31:25], bus.In[11:7]};
            4'b0010: imm_full = {{51{bus.In[31]}}, bus.In[31], bus.In[7],
                                 bus.In[30:25], bus.In[11:8], 1'b0};
            4'b0011: imm_full = {{43{bus.In[31]}}, bus.In[31], bus.In[19:12],
                                 bus.In[20], bus.In[30:21], 1'b0};
            4'b0100: imm_full = {{32{bus.In[31]}}, bus.In[31:12], 12'b0};
            4'b0101: imm_full = (XLEN == 64) ? {58'b0, bus.In[25:20]}
                                             : {59'b0, bus.In[24:20]};
`ifdef IMMGEN_RVC_EN
            4'b1000: imm_full = {{58{bus.In[12]}}, bus.In[12], bus.In[6:2]};
            4'b1001: imm_full = {57'b0, bus.In[5], bus.In[12:10], bus.In[6], 2'b0};
            4'b1010: imm_full = {{55{bus.In[12]}}, bus.In[12], bus.In[6:5], bus.In[2],
                                 bus.In[11:10], bus.In[4:3], 1'b0};
            4'b1011: imm_full = {{52{bus.In[12]}}, bus.In[12], bus.In[8], bus.In[10:9],
                                 bus.In[6], bus.In[7], bus.In[2], bus.In[11],
                                 bus.In[5:3], 1'b0};
`endif
            default: begin
                imm_full = '0;
                dec_err  = 1'b1;
            end
        endcase
    end

    assign dec_imm = imm_full[XLEN-1:0];

    // Opcode bits and the upper half of imm_full (XLEN=32) are deliberately unused.
    logic unused_bits;
    assign unused_bits = ^{bus.In[6:0], imm_full};

    // ---------------- handshake / storage ----------------
    logic            out_vld_q, out_vld_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic            out_err_q, out_err_d;
    logic            skd_vld_q, skd_vld_d;
    logic [XLEN-1:0] skd_imm_q, skd_imm_d;
    logic            skd_err_q, skd_err_d;

    logic in_rdy;
    logic in_xfer;
    logic out_xfer;

    assign in_rdy   = ~skd_vld_q;
    assign in_xfer  = bus.in_valid & in_rdy;
    assign out_xfer = out_vld_q & bus.out_ready;

    always_comb begin
        out_vld_d = out_vld_q;
        out_imm_d = out_imm_q;
        out_err_d = out_err_q;
        skd_vld_d = skd_vld_q;
        skd_imm_d = skd_imm_q;
        skd_err_d = skd_err_q;

        // Drain: the skid beat (if any) moves up behind the departing beat.
        if (out_xfer) begin
            if (skd_vld_q) begin
                out_imm_d = skd_imm_q;
                out_err_d = skd_err_q;
                skd_vld_d = 1'b0;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        // Fill: in_xfer implies the skid is empty, so it never collides with
        // the skid-to-output move above.
        if (in_xfer) begin
            if (!out_vld_q || out_xfer) begin
                out_vld_d = 1'b1;
                out_imm_d = dec_imm;
                out_err_d = dec_err;
            end else begin
                skd_vld_d = 1'b1;
                skd_imm_d = dec_imm;
                skd_err_d = dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q <= 1'b0;
            out_imm_q <= '0;
            out_err_q <= 1'b0;
            skd_vld_q <= 1'b0;
            skd_imm_q <= '0;
            skd_err_q <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            out_imm_q <= out_imm_d;
            out_err_q <= out_err_d;
            skd_vld_q <= skd_vld_d;
            skd_imm_q <= skd_imm_d;
            skd_err_q <= skd_err_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld_q;
    assign bus.Imm_Ext   = out_imm_q;
    assign bus.err       = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose: self-checking bench for imm_gen_pipe, run at XLEN=32 and XLEN=64 side by side.
// Latency: expects each result one cycle after acceptance.
// Backpressure: exercises the skid path, mid-flight reset, and random valid/ready.
module tb_imm_gen_pipe;

    logic clk;
    logic rst;

    imm_gen_pipe_if #(.XLEN(32)) b32();
    imm_gen_pipe_if #(.XLEN(64)) b64();

    imm_gen_pipe #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          x64;
        logic [31:0] ins;
        logic [3:0]  src;
        logic [63:0] exp;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic        e;
    } beat_t;

    vec_t  vecs[14];
    beat_t sb32[$];
    beat_t sb64[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] src,
                         input logic ordy);
        b32.in_valid = v;  b32.In = ins;  b32.ImmSrc = src;  b32.out_ready = ordy;
        b64.in_valid = v;  b64.In = ins;  b64.ImmSrc = src;  b64.out_ready = ordy;
    endtask

    // Reference model: assembles each immediate's field value arithmetically and
    // then applies two's-complement sign extension.
    function automatic longint fld(input logic [31:0] ins, input int hi, input int lo);
        longint w;
        w = longint'({32'b0, ins});
        return (w >> lo) & ((64'sd1 <<< (hi - lo + 1)) - 1);
    endfunction

    function automatic void ref_imm(input int xlen, input logic [31:0] ins,
                                    input logic [3:0] src,
                                    output logic [63:0] imm, output logic e);
        longint v;
        int     w;
        bit     sx;
        v  = 0;
        w  = 1;
        sx = 1'b1;
        e  = 1'b0;
        case (src)
            4'd0: begin v = fld(ins, 31, 20); w = 12; end
            4'd1: begin v = fld(ins, 31, 25) * 32 + fld(ins, 11, 7); w = 12; end
            4'd2: begin
                v = fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048
                  + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2;
                w = 13;
            end
            4'd3: begin
                v = fld(ins, 31, 31) * 1048576 + fld(ins, 19, 12) * 4096
                  + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2;
                w = 21;
            end
            4'd4: begin v = fld(ins, 31, 12) * 4096; w = 32; end
            4'd5: begin v = (xlen == 64) ? fld(ins, 25, 20) : fld(ins, 24, 20); sx = 1'b0; end
`ifdef IMMGEN_RVC_EN
            4'd8: begin v = fld(ins, 12, 12) * 32 + fld(ins, 6, 2); w = 6; end
            4'd9: begin
                v = fld(ins, 5, 5) * 64 + fld(ins, 12, 10) * 8 + fld(ins, 6, 6) * 4;
                sx = 1'b0;
            end
            4'd10: begin
                v = fld(ins, 12, 12) * 256 + fld(ins, 6, 5) * 64 + fld(ins, 2, 2) * 32
                  + fld(ins, 11, 10) * 8 + fld(ins, 4, 3) * 2;
                w = 9;
            end
            4'd11: begin
                v = fld(ins, 12, 12) * 2048 + fld(ins, 8, 8) * 1024 + fld(ins, 10, 9) * 256
                  + fld(ins, 6, 6) * 128 + fld(ins, 7, 7) * 64 + fld(ins, 2, 2) * 32
                  + fld(ins, 11, 11) * 16 + fld(ins, 5, 3) * 2;
                w = 12;
            end
`endif
            default: begin v = 0; e = 1'b1; sx = 1'b0; end
        endcase
        if (sx && v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        imm = v;
        if (xlen == 32) imm[63:32] = 32'b0;
    endfunction

    task automatic chk_dut(input bit x64, input string nm, input logic [63:0] exp,
                           input logic e);
        if (x64) begin
            chk({nm, "_vld"}, {63'b0, b64.out_valid}, 64'd1);
            chk({nm, "_imm"}, b64.Imm_Ext, exp);
            chk({nm, "_err"}, {63'b0, b64.err}, {63'b0, e});
        end else begin
            chk({nm, "_vld"}, {63'b0, b32.out_valid}, 64'd1);
            chk({nm, "_imm"}, {32'b0, b32.Imm_Ext}, exp);
            chk({nm, "_err"}, {63'b0, b32.err}, {63'b0, e});
        end
    endtask

    // One scoreboard step per DUT, sampled at the falling edge for the coming rising edge.
    task automatic sb_step(input string tag);
        beat_t b;
        if (b32.out_valid && b32.out_ready) begin
            if (sb32.size() == 0) chk({tag, "_x32_extra"}, 64'd1, 64'd0);
            else begin
                b = sb32.pop_front();
                chk({tag, "_x32_imm"}, {32'b0, b32.Imm_Ext}, b.imm);
                chk({tag, "_x32_err"}, {63'b0, b32.err}, {63'b0, b.e});
            end
        end
        if (b64.out_valid && b64.out_ready) begin
            if (sb64.size() == 0) chk({tag, "_x64_extra"}, 64'd1, 64'd0);
            else begin
                b = sb64.pop_front();
                chk({tag, "_x64_imm"}, b64.Imm_Ext, b.imm);
                chk({tag, "_x64_err"}, {63'b0, b64.err}, {63'b0, b.e});
            end
        end
        if (b32.in_valid && b32.in_ready) begin
            ref_imm(32, b32.In, b32.ImmSrc, b.imm, b.e);
            sb32.push_back(b);
        end
        if (b64.in_valid && b64.in_ready) begin
            ref_imm(64, b64.In, b64.ImmSrc, b.imm, b.e);
            sb64.push_back(b);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 32'hFFF00093, 4'b0000, 64'h00000000FFFFFFFF, 1'b0};
        vecs[1]  = '{0, 32'hFE20AE23, 4'b0001, 64'h00000000FFFFFFFC, 1'b0};
        vecs[2]  = '{0, 32'hFE000EE3, 4'b0010, 64'h00000000FFFFFFFC, 1'b0};
        vecs[3]  = '{0, 32'hFFDFF06F, 4'b0011, 64'h00000000FFFFFFFC, 1'b0};
        vecs[4]  = '{0, 32'h123450B7, 4'b0100, 64'h0000000012345000, 1'b0};
        vecs[5]  = '{0, 32'h03F0D093, 4'b0101, 64'h000000000000001F, 1'b0};
        vecs[6]  = '{0, 32'h00000000, 4'b0110, 64'h0000000000000000, 1'b1};
        vecs[7]  = '{0, 32'h00500093, 4'b0000, 64'h0000000000000005, 1'b0};
        vecs[8]  = '{1, 32'h800000B7, 4'b0100, 64'hFFFFFFFF80000000, 1'b0};
        vecs[9]  = '{1, 32'h03F0D093, 4'b0101, 64'h000000000000003F, 1'b0};
        vecs[10] = '{1, 32'h123450B7, 4'b0100, 64'h0000000012345000, 1'b0};
`ifdef IMMGEN_RVC_EN
        vecs[11] = '{0, 32'h0000557D, 4'b1000, 64'h00000000FFFFFFFF, 1'b0};
        vecs[12] = '{1, 32'h0000557D, 4'b1000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
`else
        vecs[11] = '{0, 32'h0000557D, 4'b1000, 64'h0000000000000000, 1'b1};
        vecs[12] = '{1, 32'h0000557D, 4'b1000, 64'h0000000000000000, 1'b1};
`endif
        vecs[13] = '{0, 32'hABCDEF12, 4'b1111, 64'h0000000000000000, 1'b1};

        // ---- reset state ----
        rst = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        #1;
        chk("rst_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("rst_imm",       {32'b0, b32.Imm_Ext},   64'd0);
        chk("rst_err",       {63'b0, b32.err},       64'd0);
        chk("rst_in_ready",  {63'b0, b32.in_ready},  64'd1);
        chk("rst_imm64",     b64.Imm_Ext,            64'd0);
        #10;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- table: back-to-back, out_ready held high ----
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].ins, vecs[i].src, 1'b1);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), {63'b0, b32.in_ready}, 64'd1);
            if (i > 0) chk_dut(vecs[i-1].x64, $sformatf("tbl%0d", i - 1),
                               vecs[i-1].exp, vecs[i-1].exp_err);
            @(posedge clk); #1;
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk_dut(vecs[13].x64, "tbl13", vecs[13].exp, vecs[13].exp_err);
        @(posedge clk); #1;
        @(negedge clk);
        chk("tbl_idle_vld", {63'b0, b32.out_valid}, 64'd0);
        @(posedge clk); #1;

        // ---- back-pressure: three beats offered against a stalled consumer ----
        drive(1'b1, 32'hFFF00093, 4'b0000, 1'b0);          // A
        @(negedge clk);
        chk("bp_rdy_a", {63'b0, b32.in_ready}, 64'd1);
        @(posedge clk); #1;
        drive(1'b1, 32'h123450B7, 4'b0100, 1'b0);          // B -> skid
        @(negedge clk);
        chk_dut(0, "bp_a0", 64'hFFFFFFFF, 1'b0);
        chk("bp_rdy_b", {63'b0, b32.in_ready}, 64'd1);
        @(posedge clk); #1;
        drive(1'b1, 32'hFE20AE23, 4'b0001, 1'b0);          // C held off
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("bp_full_rdy%0d", k), {63'b0, b32.in_ready}, 64'd0);
            chk_dut(0, $sformatf("bp_hold%0d", k), 64'hFFFFFFFF, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b1, 32'hFE20AE23, 4'b0001, 1'b1);          // release
        @(negedge clk);
        chk_dut(0, "bp_rel_a", 64'hFFFFFFFF, 1'b0);
        chk("bp_rel_rdy0", {63'b0, b32.in_ready}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_dut(0, "bp_rel_b", 64'h12345000, 1'b0);
        chk("bp_rel_rdy1", {63'b0, b32.in_ready}, 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk_dut(0, "bp_rel_c", 64'hFFFFFFFC, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drained", {63'b0, b32.out_valid}, 64'd0);
        @(posedge clk); #1;

        // ---- reset with output and skid registers both full ----
        drive(1'b1, 32'h00000000, 4'b0110, 1'b0);          // illegal -> err=1
        @(posedge clk); #1;
        drive(1'b1, 32'h00500093, 4'b0000, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("rm_pre_rdy", {63'b0, b32.in_ready}, 64'd0);
        chk_dut(0, "rm_pre", 64'd0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rm_async_vld", {63'b0, b32.out_valid}, 64'd0);
        chk("rm_async_imm", {32'b0, b32.Imm_Ext},   64'd0);
        chk("rm_async_err", {63'b0, b32.err},       64'd0);
        chk("rm_async_rdy", {63'b0, b32.in_ready},  64'd1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rm_nostale%0d", k), {63'b0, b32.out_valid}, 64'd0);
            chk($sformatf("rm_nostale64_%0d", k), {63'b0, b64.out_valid}, 64'd0);
        end
        @(posedge clk); #1;

        // ---- randomized traffic against the reference model ----
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0);
            @(negedge clk);
            sb_step("rnd");
            @(posedge clk); #1;
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sb_step("drain");
            @(posedge clk); #1;
        end
        chk("sb32_empty", 64'(sb32.size()), 64'd0);
        chk("sb64_empty", 64'(sb64.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
